// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Brief    : Philips I2S transmitter; each mono sample is sent on both slots,
//            buffered through a one-entry holding register.
// Revision : 1.0
// ============================================================================
module i2s_tx #(
  parameter int BCLK_DIV = 4,
  parameter int SLOT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        vld_i,
  output logic        bclk_o,
  output logic        lrclk_o,
  output logic        sdata_o,
  output logic        req_o,
  output logic        urun_o,
  output logic        orun_o
);

  localparam int c_FRAME = 2 * SLOT_W;
  localparam int c_BW    = $clog2(c_FRAME);
  localparam int c_DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [c_DW-1:0] c_DIV_MAX = c_DW'(BCLK_DIV - 1);
  localparam logic [c_BW-1:0] c_LAST    = c_BW'(c_FRAME - 1);
  localparam logic [c_BW-1:0] c_SLOT    = c_BW'(SLOT_W);
  localparam logic [c_BW-1:0] c_SLOT_M1 = c_BW'(SLOT_W - 1);
  localparam logic [c_BW-1:0] c_SAMP_W  = c_BW'(16);

  logic [c_DW-1:0] r_div_cnt;
  logic [c_BW-1:0] r_bit_cnt;
  logic [15:0]     r_hold;
  logic            r_hold_full;
  logic [15:0]     r_cur;

  logic            w_tick;
  logic            w_fall;
  logic [c_BW-1:0] w_k;
  logic [c_BW-1:0] w_p;
  logic            w_load;
  logic [15:0]     w_cur_nx;
  logic            w_lr;
  logic            w_sbit;

  assign w_tick   = (r_div_cnt == c_DIV_MAX);
  assign w_fall   = w_tick && bclk_o;
  assign w_k      = (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_p      = (w_k >= c_SLOT) ? w_k - c_SLOT : w_k;
  assign w_load   = w_fall && (w_k == '0);
  // The freshly loaded sample must already drive the MSB at the load event.
  assign w_cur_nx = (w_load && r_hold_full) ? r_hold : r_cur;
  // Word select flips one BCLK ahead of each slot's MSB.
  assign w_lr     = (w_k >= c_SLOT_M1) && (w_k != c_LAST);
  assign w_sbit   = (w_p < c_SAMP_W) ? w_cur_nx[4'd15 - w_p[3:0]] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= c_LAST;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cur       <= '0;
      bclk_o      <= 1'b0;
      lrclk_o     <= 1'b0;
      sdata_o     <= 1'b0;
      req_o       <= 1'b0;
      urun_o      <= 1'b0;
      orun_o      <= 1'b0;
    end else begin
      req_o  <= 1'b0;
      urun_o <= 1'b0;
      orun_o <= vld_i && r_hold_full && !w_load;

      if (w_tick) begin
        r_div_cnt <= '0;
        bclk_o    <= ~bclk_o;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (w_fall) begin
        r_bit_cnt <= w_k;
        lrclk_o   <= w_lr;
        sdata_o   <= w_sbit;
      end

      if (w_load) begin
        if (r_hold_full) begin
          r_cur <= r_hold;
          req_o <= 1'b1;
        end else begin
          urun_o <= 1'b1;
        end
      end

      // A coincident strobe lands in the holding register after the old value moved out.
      if (vld_i) begin
        r_hold <= data_i;
      end
      r_hold_full <= vld_i || (r_hold_full && !w_load);
    end
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Output stage directly downstream of eff_pipe: consumes its processed sample stream (data/vld) and serializes it to the board DAC as Philips I2S.
- Generates BCLK and LRCLK from the system clock.
- Sends each mono sample on both left and right slots.
- Decouples the irregular vld cadence from the fixed frame rate with a one-entry holding register, and flags underrun/overrun.

Parameters:
- BCLK_DIV, 4, clk cycles per BCLK half-period; legal values >= 1.
- SLOT_W, 32, BCLK periods per channel slot; legal values >= 16.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data_i  in  16  sample_pkg::sample_t, signed 16-bit sample from eff_pipe
- vld_i  in  1  data_i valid, single-cycle strobe, no backpressure
- bclk_o  out  1  I2S bit clock
- lrclk_o  out  1  I2S word select; 0 = left, 1 = right
- sdata_o  out  1  I2S serial data, MSB first
- req_o  out  1  one-cycle pulse when the holding register is consumed at a frame load
- urun_o  out  1  one-cycle pulse: frame load found the holding register empty
- orun_o  out  1  one-cycle pulse: unconsumed held sample was overwritten

Behaviour:
- Reset, asynchronous and active-high, sets:
  - bclk_o, lrclk_o, sdata_o, req_o, urun_o, orun_o = 0
  - div_cnt = 0
  - bit_cnt = 2*SLOT_W-1
  - hold register = 0, hold_full = 0
  - shift/current sample = 0
- Every output is a register. There is no combinational path from input to output.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1.
  - When div_cnt == BCLK_DIV-1, bclk_o toggles and div_cnt returns to 0.
- A toggle taking bclk_o 1->0 is a fall event. All I2S state changes only on fall events, in the same clk cycle bclk_o falls.
- At each fall event:
  - bit_cnt <= (bit_cnt == 2*SLOT_W-1) ? 0 : bit_cnt+1.
  - Let k be the new bit_cnt.
  - Slot position p = k mod SLOT_W.
  - sdata_o = cur[15-p] for p < 16, else 0.
  - lrclk_o = 1 iff ((k+1) mod 2*SLOT_W) >= SLOT_W. LRCLK therefore leads the MSB by one BCLK, per I2S.
- Frame load happens at the fall event where k wraps to 0:
  - If hold_full: cur <= hold, hold_full <= 0, req_o pulses. The MSB driven at that event is the new sample's MSB.
  - If not hold_full: cur is unchanged, so the last sample repeats (0 after reset), and urun_o pulses.
- Input capture:
  - vld_i=1 writes hold <= data_i and sets hold_full.
  - If hold_full was already set and no frame load occurs that cycle, orun_o pulses and the newer sample wins.
- Simultaneous vld_i and frame load, hold_full = 1:
  - The old hold value goes to cur and req_o pulses.
  - data_i goes to hold and hold_full stays 1.
  - No orun.
- Simultaneous vld_i and frame load, hold_full = 0:
  - There is no bypass; urun_o pulses and cur is unchanged.
  - data_i is captured into hold and sent on the next frame.
- Both slots transmit cur. Bits beyond 16 in a slot are zero-padded.
- Frame period is 2*SLOT_W*2*BCLK_DIV clk cycles.
- Reset mid-frame: all outputs go to their reset values immediately. The first fall event after release is bit 0 of a new left slot.

Test Plan:
1. Reset values. Assert rst mid-frame with BCLK_DIV=2, SLOT_W=32 -> all outputs 0 within the same cycle. After release, bclk_o rises at clk 2 and falls at clk 4. At clk 4, lrclk_o=0 and the frame load occurs: urun_o=1, sdata_o=0.
2. Single sample. vld_i with data_i=16'hA5C3 before the first fall -> req_o pulses at the first fall. On BCLK rising edges: left slot samples 1010_0101_1100_0011 then 16 zeros, with lrclk_o=0. lrclk_o goes 1 on the fall of left bit 31. The right slot repeats the same pattern.
3. Underrun repeat. After test 2, send no further vld_i -> the next frame load pulses urun_o and re-sends 16'hA5C3 on both slots.
4. Overrun. vld_i 16'h1111 then 16'h7FFF within one frame -> orun_o pulses exactly once on the second strobe. The next frame sends 7FFF, and req_o pulses.
5. Coincident vld_i with empty hold. Drive vld_i 16'h8000 in the frame-load cycle -> urun_o=1 that cycle and the old sample is sent. The next frame sends 8000 (MSB 1, then 15 zeros) with a req_o pulse.
6. Coincident vld_i with full hold. Preload 16'h0001, then drive vld_i 16'h0002 in the load cycle -> 0001 is sent, no orun, and the following frame sends 0002.
